// File: rtl/alu_pkg.sv
// alu_pkg: opcode group/function constants, mul/div FSM state type and the
// iteration count shared by alu_unit and alu_muldiv.
package alu_pkg;

   // Opcode groups, op[4:3]
   localparam logic [1:0] GrpBase = 2'b00;
   localparam logic [1:0] GrpAlt  = 2'b01;
   localparam logic [1:0] GrpCmp  = 2'b10;
   localparam logic [1:0] GrpMd   = 2'b11;

   // Group 00 functions
   localparam logic [2:0] F3Add  = 3'd0;
   localparam logic [2:0] F3Sll  = 3'd1;
   localparam logic [2:0] F3Slt  = 3'd2;
   localparam logic [2:0] F3Sltu = 3'd3;
   localparam logic [2:0] F3Xor  = 3'd4;
   localparam logic [2:0] F3Srl  = 3'd5;
   localparam logic [2:0] F3Or   = 3'd6;
   localparam logic [2:0] F3And  = 3'd7;

   // Group 01 functions
   localparam logic [2:0] F3Sub  = 3'd0;
   localparam logic [2:0] F3Sra  = 3'd5;

   // Group 10 functions
   localparam logic [2:0] F3Eq   = 3'd0;
   localparam logic [2:0] F3Ne   = 3'd1;
   localparam logic [2:0] F3Lt   = 3'd4;
   localparam logic [2:0] F3Ge   = 3'd5;
   localparam logic [2:0] F3Ltu  = 3'd6;
   localparam logic [2:0] F3Geu  = 3'd7;

   // Group 11 functions
   localparam logic [2:0] F3Mul    = 3'd0;
   localparam logic [2:0] F3Mulh   = 3'd1;
   localparam logic [2:0] F3Mulhsu = 3'd2;
   localparam logic [2:0] F3Mulhu  = 3'd3;
   localparam logic [2:0] F3Div    = 3'd4;
   localparam logic [2:0] F3Divu   = 3'd5;
   localparam logic [2:0] F3Rem    = 3'd6;
   localparam logic [2:0] F3Remu   = 3'd7;

   // One shift-add / restoring-subtract step per operand bit
   localparam int unsigned IterCount = 32;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } md_state_e;

   // Illegal codes in groups 00..10; group 11 legality depends on the build.
   function automatic logic base_illegal(input logic [4:0] op);
      logic bad;
      bad = 1'b0;
      if (op[4:3] == GrpAlt) begin
         bad = (op[2:0] != F3Sub) && (op[2:0] != F3Sra);
      end else if (op[4:3] == GrpCmp) begin
         bad = (op[2:0] == 3'd2) || (op[2:0] == 3'd3);
      end
      return bad;
   endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative 32-step multiply/divide on operand magnitudes with a
// final sign fix-up. start/busy/done handshake; done pulses in the last RUN
// cycle while result carries the final value for the parent to register.
module alu_muldiv
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        hold,
   input  logic [2:0]  funct,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        idle,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d, acc_step;
   logic [31:0] opd_q, opd_d;
   logic [31:0] a_q, a_d;
   logic [2:0]  funct_q, funct_d;
   logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d, zero_q, zero_d;

   logic        a_signed, b_signed, neg_a, neg_b;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum, div_rem, div_diff;
   logic        div_ge;
   logic [63:0] prod;
   logic [31:0] quo, rem;

   // Operand sign handling at launch
   always_comb begin
      a_signed = funct inside {F3Mulh, F3Mulhsu, F3Div, F3Rem};
      b_signed = funct inside {F3Mulh, F3Div, F3Rem};
      neg_a    = a_signed & a[31];
      neg_b    = b_signed & b[31];
      mag_a    = neg_a ? (~a + 32'd1) : a;
      mag_b    = neg_b ? (~b + 32'd1) : b;
   end

   // One iteration: acc = {hi, lo}; mul shifts right, div shifts left
   always_comb begin
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
      div_rem  = {acc_q[63:32], acc_q[31]};
      div_diff = div_rem - {1'b0, opd_q};
      div_ge   = (div_rem >= {1'b0, opd_q});
      if (funct_q[2]) begin
         acc_step = {(div_ge ? div_diff[31:0] : div_rem[31:0]), acc_q[30:0], div_ge};
      end else begin
         acc_step = {mul_sum, acc_q[31:1]};
      end
   end

   // Next-state: launch, iterate, then wait for enable to drop
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      a_d     = a_q;
      funct_d = funct_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      zero_d  = zero_q;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cnt_d   = '0;
               funct_d = funct;
               neg_a_d = neg_a;
               neg_b_d = neg_b;
               zero_d  = (b == 32'd0);
               a_d     = a;
               if (funct[2]) begin
                  opd_d = mag_b;
                  acc_d = {32'd0, mag_a};
               end else begin
                  opd_d = mag_a;
                  acc_d = {32'd0, mag_b};
               end
            end
         end
         StRun: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(IterCount - 1)) begin
               state_d = StDone;
               done    = 1'b1;
            end
         end
         StDone: begin
            if (!hold) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Final result from the last step, with sign fix-up and divide-by-zero override
   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? (~acc_step + 64'd1) : acc_step;
      quo  = acc_step[31:0];
      rem  = acc_step[63:32];
      if (neg_a_q ^ neg_b_q) quo = ~quo + 32'd1;
      if (neg_a_q) rem = ~rem + 32'd1;
      if (zero_q) begin
         quo = '1;
         rem = a_q;
      end
      case (funct_q)
         F3Mul:                      result = prod[31:0];
         F3Mulh, F3Mulhsu, F3Mulhu:  result = prod[63:32];
         F3Div, F3Divu:              result = quo;
         default:                    result = rem;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         a_q     <= '0;
         funct_q <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         a_q     <= a_d;
         funct_q <= funct_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         zero_q  <= zero_d;
      end
   end

   assign idle = (state_q == StIdle);
   assign busy = (idle & start) | (state_q == StRun);

endmodule

// File: rtl/alu_unit.sv
// alu_unit: single-cycle integer ALU with an optional iterative mul/div unit.
// Build option: define ALU_MULDIV_EN to implement opcode group 11; otherwise
// every group-11 code faults and busy stays low.
module alu_unit
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [4:0]  op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] out,
   output logic        busy,
   output logic        fault
);

   logic [1:0]  grp;
   logic [2:0]  f3;
   logic [4:0]  shamt;
   logic        illegal;
   logic        lt_s, lt_u, eq;
   logic [31:0] alu_res;
   logic [31:0] out_q, out_d;
   logic        md_idle, md_busy, md_done;
   logic [31:0] md_result;

   assign grp   = op[4:3];
   assign f3    = op[2:0];
   assign shamt = in_b[4:0];
   assign lt_s  = $signed(in_a) < $signed(in_b);
   assign lt_u  = in_a < in_b;
   assign eq    = in_a == in_b;

   // Illegal-op decode; group 11 is legal only when the mul/div unit exists
   always_comb begin
      illegal = base_illegal(op);
`ifndef ALU_MULDIV_EN
      if (grp == GrpMd) illegal = 1'b1;
`endif
   end

   // Single-cycle datapath for groups 00..10
   always_comb begin
      alu_res = '0;
      case (grp)
         GrpBase: begin
            case (f3)
               F3Add:   alu_res = in_a + in_b;
               F3Sll:   alu_res = in_a << shamt;
               F3Slt:   alu_res = {31'b0, lt_s};
               F3Sltu:  alu_res = {31'b0, lt_u};
               F3Xor:   alu_res = in_a ^ in_b;
               F3Srl:   alu_res = in_a >> shamt;
               F3Or:    alu_res = in_a | in_b;
               default: alu_res = in_a & in_b;
            endcase
         end
         GrpAlt: begin
            if (f3 == F3Sra) alu_res = $signed(in_a) >>> shamt;
            else             alu_res = in_a - in_b;
         end
         GrpCmp: begin
            case (f3)
               F3Eq:    alu_res = {31'b0, eq};
               F3Ne:    alu_res = {31'b0, !eq};
               F3Lt:    alu_res = {31'b0, lt_s};
               F3Ge:    alu_res = {31'b0, !lt_s};
               F3Ltu:   alu_res = {31'b0, lt_u};
               F3Geu:   alu_res = {31'b0, !lt_u};
               default: alu_res = '0;
            endcase
         end
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic md_start;
   assign md_start = enable & (grp == GrpMd);

   alu_muldiv u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .hold   (enable),
      .funct  (f3),
      .a      (in_a),
      .b      (in_b),
      .idle   (md_idle),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );
`else
   assign md_idle   = 1'b1;
   assign md_busy   = 1'b0;
   assign md_done   = 1'b0;
   assign md_result = '0;
`endif

   // Pick what the output register loads; single-cycle ops only launch from IDLE
   always_comb begin
      out_d = out_q;
      if (md_done) begin
         out_d = md_result;
      end else if (md_idle && enable && !illegal && (grp != GrpMd)) begin
         out_d = alu_res;
      end
   end

   // Output register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) out_q <= '0;
      else        out_q <= out_d;
   end

   assign out   = out_q;
   assign busy  = reset & md_busy;
   assign fault = reset & enable & illegal;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed self-checking bench; expected results are queued when
// stimulus is driven and popped when the DUT's registered output is sampled.
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [4:0]  op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] out;
   logic        busy;
   logic        fault;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_out;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   alu_unit dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .op     (op),
      .in_a   (in_a),
      .in_b   (in_b),
      .out    (out),
      .busy   (busy),
      .fault  (fault)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; op = 5'b00000; in_a = 32'h1234; in_b = 32'h1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_out: got %h want %h", out, 32'h0);
      end
      enable = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || fault !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got busy=%b fault=%b want 0 0", busy, fault);
      end
      @(negedge clk);
      reset = 1'b1;
      last_out = 32'h0;
   endtask

   task automatic test_single();
      vec_t vt[$];
      logic [31:0] want;
      vt.push_back('{5'b00000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001}); // ADD wrap
      vt.push_back('{5'b01101, 32'h80000000, 32'h00000024, 32'hF8000000}); // SRA
      vt.push_back('{5'b10100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}); // LT
      vt.push_back('{5'b10110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}); // LTU
      vt.push_back('{5'b00001, 32'h00000001, 32'h00000021, 32'h00000002}); // SLL
      vt.push_back('{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}); // SLT
      vt.push_back('{5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}); // SLTU
      vt.push_back('{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0}); // XOR
      vt.push_back('{5'b00101, 32'h80000000, 32'h00000004, 32'h08000000}); // SRL
      vt.push_back('{5'b00110, 32'hF0000000, 32'h0000000F, 32'hF000000F}); // OR
      vt.push_back('{5'b00111, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00}); // AND
      vt.push_back('{5'b01000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF}); // SUB wrap
      vt.push_back('{5'b10000, 32'h00000005, 32'h00000005, 32'h00000001}); // EQ
      vt.push_back('{5'b10001, 32'h00000005, 32'h00000005, 32'h00000000}); // NE
      vt.push_back('{5'b10101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}); // GE
      vt.push_back('{5'b10111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}); // GEU
      foreach (vt[i]) begin
         @(negedge clk);
         enable = 1'b1; op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b;
         exp_q.push_back(vt[i].res);
         #1;
         vectors++;
         if (busy !== 1'b0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL single_flags op=%b: got busy=%b fault=%b want 0 0", vt[i].op, busy,
                     fault);
         end
         @(posedge clk);
         #1;
         enable = 1'b0;
         want = exp_q.pop_front();
         vectors++;
         if (out !== want) begin
            miscompares++;
            $display("FAIL single_out op=%b: got %h want %h", vt[i].op, out, want);
         end
         last_out = want;
      end
   endtask

   task automatic test_fault();
      logic [4:0] bad[$];
      bad.push_back(5'b01001);
      bad.push_back(5'b01111);
      bad.push_back(5'b10010);
      bad.push_back(5'b10011);
      foreach (bad[i]) begin
         @(negedge clk);
         enable = 1'b1; op = bad[i]; in_a = 32'h11111111; in_b = 32'h22222222;
         #1;
         vectors++;
         if (fault !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_flags op=%b: got fault=%b busy=%b want 1 0", bad[i], fault, busy);
         end
         @(posedge clk);
         #1;
         enable = 1'b0;
         vectors++;
         if (out !== last_out) begin
            miscompares++;
            $display("FAIL fault_out op=%b: got %h want %h", bad[i], out, last_out);
         end
      end
      #1;
      vectors++;
      if (fault !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_idle: got %b want 0", fault);
      end
   endtask

   task automatic test_idle_hold();
      @(negedge clk);
      enable = 1'b0; op = 5'b00000; in_a = 32'h00000100; in_b = 32'h00000200;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (out !== last_out) begin
         miscompares++;
         $display("FAIL idle_hold: got %h want %h", out, last_out);
      end
   endtask

   task automatic test_back_to_back();
      vec_t vt[$];
      logic [31:0] want;
      vt.push_back('{5'b00000, 32'h00000003, 32'h00000004, 32'h00000007}); // ADD
      vt.push_back('{5'b00100, 32'h000000FF, 32'h0000000F, 32'h000000F0}); // XOR
      vt.push_back('{5'b00110, 32'h00000100, 32'h00000001, 32'h00000101}); // OR
      @(negedge clk);
      enable = 1'b1;
      foreach (vt[i]) begin
         op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b;
         exp_q.push_back(vt[i].res);
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         vectors++;
         if (out !== want) begin
            miscompares++;
            $display("FAIL b2b_out[%0d]: got %h want %h", i, out, want);
         end
         last_out = want;
         @(negedge clk);
      end
      enable = 1'b0;
   endtask

`ifdef ALU_MULDIV_EN
   task automatic test_muldiv();
      vec_t vt[$];
      logic [31:0] want;
      int n;
      vt.push_back('{5'b11100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000}); // DIV overflow
      vt.push_back('{5'b11101, 32'h00003039, 32'h00000000, 32'hFFFFFFFF}); // DIVU by 0
      vt.push_back('{5'b11000, 32'h00000007, 32'h00000006, 32'h0000002A}); // MUL
      vt.push_back('{5'b11100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF}); // DIV by 0
      vt.push_back('{5'b11110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9}); // REM by 0
      vt.push_back('{5'b11100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD}); // DIV -7/2
      vt.push_back('{5'b11110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF}); // REM -7%2
      vt.push_back('{5'b11110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}); // REM overflow
      vt.push_back('{5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}); // MULHU
      vt.push_back('{5'b11010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}); // MULHSU
      vt.push_back('{5'b11001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000}); // MULH
      vt.push_back('{5'b11111, 32'h00000064, 32'h00000007, 32'h00000002}); // REMU
      foreach (vt[i]) begin
         @(negedge clk);
         enable = 1'b1; op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b;
         exp_q.push_back(vt[i].res);
         #1;
         n = 0;
         while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
         end
         vectors++;
         if (n != 33) begin
            miscompares++;
            $display("FAIL md_busy_cycles op=%b: got %0d want 33", vt[i].op, n);
         end
         want = exp_q.pop_front();
         vectors++;
         if (out !== want) begin
            miscompares++;
            $display("FAIL md_out op=%b a=%h b=%h: got %h want %h", vt[i].op, vt[i].a, vt[i].b,
                     out, want);
         end
         // enable still high in DONE must not relaunch
         @(posedge clk);
         #1;
         vectors++;
         if (busy !== 1'b0 || out !== want) begin
            miscompares++;
            $display("FAIL md_no_restart: got busy=%b out=%h want 0 %h", busy, out, want);
         end
         @(negedge clk);
         enable = 1'b0;
         @(posedge clk);
         #1;
         last_out = want;
      end
   endtask

   task automatic test_reset_in_run();
      @(negedge clk);
      enable = 1'b1; op = 5'b11100; in_a = 32'h00000064; in_b = 32'h00000007;
      repeat (11) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL run_busy: got %b want 1", busy);
      end
      @(negedge clk);
      reset = 1'b0; enable = 1'b0;
      exp_q.push_back(32'h0);
      @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || out !== exp_q.pop_front()) begin
         miscompares++;
         $display("FAIL run_reset: got busy=%b out=%h want 0 00000000", busy, out);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      vectors++;
      if (out !== 32'h0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL run_abort: got out=%h busy=%b want 00000000 0", out, busy);
      end
      last_out = 32'h0;
   endtask
`else
   task automatic test_md_illegal();
      logic [4:0] mdops[$];
      mdops.push_back(5'b11000);
      mdops.push_back(5'b11100);
      foreach (mdops[i]) begin
         @(negedge clk);
         enable = 1'b1; op = mdops[i]; in_a = 32'h7; in_b = 32'h6;
         #1;
         vectors++;
         if (fault !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL md_illegal op=%b: got fault=%b busy=%b want 1 0", mdops[i], fault,
                     busy);
         end
         @(posedge clk);
         #1;
         enable = 1'b0;
         vectors++;
         if (out !== last_out) begin
            miscompares++;
            $display("FAIL md_illegal_out op=%b: got %h want %h", mdops[i], out, last_out);
         end
      end
   endtask
`endif

   initial begin
      reset = 1'b0; enable = 1'b0; op = '0; in_a = '0; in_b = '0; last_out = '0;
      test_reset();
      test_single();
      test_fault();
      test_idle_hold();
      test_back_to_back();
`ifdef ALU_MULDIV_EN
      test_muldiv();
      test_reset_in_run();
`else
      test_md_illegal();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-low reset, sampled on the `clk` rising edge.
REQ-004 Port `enable`, input, 1 bit: level-high request; held high for the whole execute stage.
REQ-005 Port `op`, input, 5 bits: operation code, decoded per REQ-010.
REQ-006 Port `in_a`, input, 32 bits: operand A.
REQ-007 Port `in_b`, input, 32 bits: operand B.
REQ-008 Port `out`, output, 32 bits: registered result, held until the next accepted operation.
REQ-009 Ports `busy` and `fault`, output, 1 bit each: `busy` = operation in progress; `fault` = illegal op.

Function
REQ-010 `op[4:3]` SHALL select the group and `op[2:0]` the function:
- 00: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND (f3 = 0..7).
- 01: SUB (f3 = 0), SRA (f3 = 5); any other f3 is illegal.
- 10: EQ, NE, –, –, LT, GE, LTU, GEU; f3 = 2 or 3 is illegal.
- 11: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-011 Shift amounts SHALL be `in_b[4:0]`; arithmetic SHALL wrap modulo 2^32.
REQ-012 SLT/SLTU and group-10 compares SHALL write `out = {31'b0, result}`.
REQ-013 Single-cycle ops (groups 00–10) SHALL register `out` on the first rising edge with `enable = 1` in IDLE, with `busy` never asserted.
REQ-014 Group 11 SHALL run an iterative FSM with states IDLE, RUN, DONE:
- IDLE->RUN on the edge with `enable = 1`; operands latch and the counter clears.
- RUN lasts 32 edges; the last RUN edge writes `out` and moves to DONE.
- DONE->IDLE when `enable = 0`.
REQ-015 `busy` SHALL be combinational: `(IDLE & enable & group 11) | RUN`. It is therefore high for exactly 33 cycles, starting in the enable cycle.
REQ-016 In DONE, `enable` held high SHALL NOT restart the operation.
REQ-017 Divide by zero SHALL give: quotient 0xFFFFFFFF (DIV and DIVU); remainder = `in_a`.
REQ-018 Signed overflow (0x80000000 / -1) SHALL give quotient 0x80000000 and remainder 0.
REQ-019 `fault` SHALL be combinational: `enable & illegal op`.
REQ-020 A faulting op SHALL leave `out` unchanged, keep `busy` low, and not change state.
REQ-021 `enable = 0` while in IDLE SHALL leave `out` unchanged.

Reset
REQ-022 With `reset = 0` at a rising edge: `out = 0`, state = IDLE, counter = 0, and `busy` and `fault` read 0.
REQ-023 Reset in RUN SHALL abort the operation with no `out` update.
REQ-024 Reset SHALL take priority over `enable`.

Configuration
REQ-025 Macro `ALU_MULDIV_EN` SHALL control group 11:
- Defined: group 11 is implemented per REQ-014..018.
- Undefined: all group-11 codes are illegal per REQ-019/020, the FSM and datapath are omitted, and `busy` is tied to 0.

Structure
REQ-026 Package `alu_pkg` SHALL hold the group/function code constants, the FSM state enum, and the iteration-count constant (32).
REQ-027 The iterative multiply/divide SHALL be a sub-module `alu_muldiv` with start/busy/done handshake, present only under `ALU_MULDIV_EN`.
REQ-028 All sequential logic SHALL be clocked by `clk` only; no gated clocks.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- ADD: op=00000, a=0xFFFFFFFF, b=2 -> `out` = 0x00000001 after one edge; `busy` = 0 throughout.
- SRA: op=01101, a=0x80000000, b=0x24 (shift 4) -> `out` = 0xF8000000.
- LT: op=10100, a=-1, b=1 -> `out` = 1. LTU with the same operands (op=10110) -> `out` = 0.
- Illegal op=01001 with `enable` high -> `fault` = 1 that cycle; `out` keeps its prior value.
- DIV: op=11100, a=0x80000000, b=0xFFFFFFFF -> `busy` high for 33 cycles, then `out` = 0x80000000. DIVU by 0 -> `out` = 0xFFFFFFFF. MUL 7*6 -> `out` = 42.
- Reset (`reset` = 0) at RUN cycle 10 -> `busy` = 0 and `out` = 0 next cycle. With `ALU_MULDIV_EN` undefined, op=11000 -> `fault` = 1.
